mux_4b_4_1_rr: RTL
==================

MUX_4B_4_1_RR -- requirements
Module: mux_4b_4_1_rr

Interface
REQ-001 SHALL have parameter W, default 4, data width of every input and output word.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports d0,d1,d2,d3  input  W each  source data words, one per channel.
REQ-005 SHALL have ports v0,v1,v2,v3  input  1 each  source valid, one per channel.
REQ-006 SHALL have ports r0,r1,r2,r3  output  1 each  source ready; transfer on channel i when vi && ri at a rising edge.
REQ-007 SHALL have port y  output  W  merged output word, registered.
REQ-008 SHALL have port sel  output  2  index of the channel that supplied y, registered.
REQ-009 SHALL have port y_valid  output  1  y/sel hold a word, registered.
REQ-010 SHALL have port y_ready  input  1  sink accepts; output transfer when y_valid && y_ready at a rising edge.

Function
REQ-011 SHALL implement a two-state output stage: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-012 SHALL define "slot free" = EMPTY, or FULL && y_ready in the same cycle.
REQ-013 SHALL, when slot free and at least one vi=1, grant exactly one channel g by round-robin: search order last+1, last+2, last+3, last (mod 4).
REQ-014 SHALL drive rg=1 combinationally for the granted channel only in that cycle; all other ri=0; all ri=0 when slot not free.
REQ-015 SHALL on a grant edge load y<=dg, sel<=g, y_valid<=1, last<=g (FULL); latency from capture edge to y_valid=1 is one clock.
REQ-016 SHALL, when slot free and no vi=1, go to/stay EMPTY (y_valid<=0); y and sel keep their last values.
REQ-017 SHALL, when FULL && !y_ready, hold y, sel, y_valid, last unchanged regardless of vi/di.
REQ-018 SHALL support simultaneous drain and capture: FULL && y_ready && some vi=1 loads the new word on the same edge, giving one word per clock sustained throughput.
REQ-019 SHALL wrap the round-robin pointer 3 -> 0; with all four vi=1 continuously and y_ready=1, sel SHALL cycle 0,1,2,3,0,...
REQ-020 SHALL never starve: a channel holding vi=1 SHALL be granted within 4 slot-free cycles.
REQ-021 SHALL ignore di of non-granted channels and of any channel with vi=0.

Reset
REQ-022 SHALL on rst=1 at a rising edge set y_valid=0, y=0, sel=0, last=3 (so channel 0 has first priority).
REQ-023 SHALL drive all ri=0 while rst=1.
REQ-024 SHALL discard any held word on reset mid-operation; no partial transfer SHALL be reported after the reset edge.

Structure
REQ-025 SHALL place the state encoding (EMPTY/FULL) and channel count constant (4) in the shared package header included by the mux/demux family.
REQ-026 SHALL factor the round-robin grant logic into one combinational sub-module rr_arb_4 (inputs: 4 requests, 2-bit last; outputs: one-hot grant, 2-bit index, any).
REQ-027 SHALL keep all registers in the top module; rr_arb_4 SHALL contain no state.

Verification
REQ-028 Bench SHALL apply rst for 2 cycles with all vi=1 -> y_valid=0, y=0, sel=0, all ri=0 during reset.
REQ-029 Bench SHALL set v1=1, d1=4'b0101, others 0, y_ready=1 -> r1=1 for one cycle, next cycle y=4'b0101, sel=1, y_valid=1.
REQ-030 Bench SHALL hold v0..v3=1 with d0..d3=1,2,3,4 and y_ready=1 -> sel sequence 0,1,2,3,0 and y 1,2,3,4,1 on consecutive clocks.
REQ-031 Bench SHALL hold y_ready=0 for 3 cycles while FULL with y=4'b1010 and v2=1 -> y, sel stable, r2=0; on y_ready=1, r2=1 and next word loads same edge.
REQ-032 Bench SHALL drop all vi to 0 while FULL with y_ready=1 -> y_valid=0 next cycle, y unchanged.
REQ-033 Bench SHALL assert rst while FULL and y_ready=0 -> next cycle y_valid=0, and first grant after release goes to channel 0 when all vi=1.

Source files
------------

// File: rtl/mux_4b_4_1_rr_pkg.sv
// Shared constants and types for the round-robin mux/demux family.
package mux_4b_4_1_rr_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // Output holding-stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Channel index k positions after base, wrapping modulo NUM_CH.
  function automatic logic [CH_W-1:0] ch_offset(input logic [CH_W-1:0] base,
                                                 input logic [CH_W-1:0] k);
    return base + k;
  endfunction

endpackage

// File: rtl/mux_4b_4_1_rr_rr_arb_4.sv
// Stateless 4-way round-robin arbiter: the channel just after i_last wins,
// i_last itself has the lowest priority.
module rr_arb_4
  import mux_4b_4_1_rr_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  logic [CH_W-1:0] w_cand;

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    o_gnt  = '0;
    o_idx  = i_last;
    o_any  = 1'b0;
    w_cand = i_last;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_cand = ch_offset(i_last, k[CH_W-1:0]);
      if (i_req[w_cand]) begin
        o_gnt = NUM_CH'(1) << w_cand;
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4b_4_1_rr.sv
// 4:1 valid/ready merge with round-robin arbitration and a one-word
// registered output stage that can drain and refill on the same edge.
module mux_4b_4_1_rr
  import mux_4b_4_1_rr_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic         v0,
  input  logic         v1,
  input  logic         v2,
  input  logic         v3,
  output logic         r0,
  output logic         r1,
  output logic         r2,
  output logic         r3,
  output logic [W-1:0] y,
  output logic [1:0]   sel,
  output logic         y_valid,
  input  logic         y_ready
);

  out_state_e                   r_state;
  logic [W-1:0]                 r_y;
  logic [CH_W-1:0]              r_sel;
  logic [CH_W-1:0]              r_last;

  logic [NUM_CH-1:0]            w_req;
  logic [NUM_CH-1:0][W-1:0]     w_data;
  logic [NUM_CH-1:0]            w_gnt;
  logic [CH_W-1:0]              w_idx;
  logic                         w_any;
  logic                         w_slot_free;
  logic                         w_take;
  logic [NUM_CH-1:0]            w_ready;

  assign w_req  = {v3, v2, v1, v0};
  assign w_data = {d3, d2, d1, d0};

  rr_arb_4 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Slot can accept a word if empty or being drained this cycle.
  assign w_slot_free = (r_state == ST_EMPTY) || y_ready;
  assign w_take      = w_slot_free && w_any && !rst;
  assign w_ready     = w_gnt & {NUM_CH{w_take}};

  assign r0      = w_ready[0];
  assign r1      = w_ready[1];
  assign r2      = w_ready[2];
  assign r3      = w_ready[3];
  assign y       = r_y;
  assign sel     = r_sel;
  assign y_valid = (r_state == ST_FULL);

  // Output stage: capture the granted word, go empty when nothing is offered,
  // hold everything while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
      r_sel   <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else if (w_slot_free) begin
      if (w_any) begin
        r_state <= ST_FULL;
        r_y     <= w_data[w_idx];
        r_sel   <= w_idx;
        r_last  <= w_idx;
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

endmodule
